// File: rtl/lnp_pkg.sv
// Shared definitions for the last-node TSN tag restore block: word-type codes,
// bit-field offsets of the head word, the TSN tag and restore-table entries, and FSM states.
package lnp_pkg;

    localparam int WORD_W = 134;
    localparam int MAC_W  = 48;

    // Word-type field at the top of each 134-bit word
    localparam int TYPE_HI = 133;
    localparam int TYPE_LO = 132;
    localparam logic [1:0] WT_HEAD = 2'b01;
    localparam logic [1:0] WT_BODY = 2'b11;
    localparam logic [1:0] WT_TAIL = 2'b10;

    // DMAC field of the head word, which carries the TSN tag on the way in
    localparam int DMAC_HI = 127;
    localparam int DMAC_LO = 80;

    // Flow ID position inside the 48-bit tag
    localparam int TAG_FID_LO = 31;

    // Restore-table entry layout: {valid, flowid, dmac}
    localparam int ENT_DMAC_LO = 0;
    localparam int ENT_FID_LO  = MAC_W;

    localparam logic [MAC_W-1:0] BCAST_MAC = {MAC_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_DROP = 2'd2
    } lnp_state_e;

    function automatic logic [1:0] word_type(input logic [WORD_W-1:0] w);
        return w[TYPE_HI:TYPE_LO];
    endfunction

endpackage

// File: rtl/lnp_restore_table.sv
// Flow-ID to original-DMAC restore table: true dual-port RAM with registered reads.
// Port A serves the CPU (read/write), port B serves the packet lookup (read-only).
module lnp_restore_table
    import lnp_pkg::*;
#(
    parameter int IDX_W  = 5,
    parameter int DATA_W = 63
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  a_addr,
    input  logic              a_wr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              a_rd,
    output logic [DATA_W-1:0] a_rdata,
    input  logic [IDX_W-1:0]  b_addr,
    output logic [DATA_W-1:0] b_rdata
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it can map onto block RAM; software initialises it.
    always_ff @(posedge clk) begin
        if (a_wr) begin
            mem[a_addr] <= a_wdata;
        end
    end

    // Both read ports return the pre-write contents when a write hits the same address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata <= '0;
        end else if (a_rd) begin
            a_rdata <= mem[a_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_rdata <= '0;
        end else begin
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/last_node_process.sv
// Last TSN node egress: replaces the TSN tag in each head word's DMAC with the original
// DMAC from the restore table. Optional macro LNP_MISS_PASS_EN forwards misses as broadcast.
module last_node_process
    import lnp_pkg::*;
#(
    parameter int IDX_W    = 5,
    parameter int FLOWID_W = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WORD_W-1:0]             iv_lnp_pkt_data,
    input  logic                          i_lnp_pkt_data_wr,
    input  logic [IDX_W-1:0]              iv_lnp_rmt_ram_addr,
    input  logic                          i_lnp_rmt_ram_wr,
    input  logic [1+FLOWID_W+MAC_W-1:0]   iv_lnp_rmt_ram_wdata,
    input  logic                          i_lnp_rmt_ram_rd,
    output logic [1+FLOWID_W+MAC_W-1:0]   ov_lnp_rmt_ram_rdata,
    output logic [WORD_W-1:0]             ov_lnp_pkt_data,
    output logic                          o_lnp_pkt_data_wr,
    input  logic                          i_lnp_fifo_full,
    output logic                          o_lnp_inpkt_pulse,
    output logic                          o_lnp_outpkt_pulse,
    output logic                          o_lnp_miss_pulse,
    output logic                          o_lnp_lost_head_pulse,
    output logic                          o_lnp_fifo_overflow
);

    localparam int ENT_W     = 1 + FLOWID_W + MAC_W;
    localparam int ENT_VALID = FLOWID_W + MAC_W;
    localparam int FID_BIT   = DMAC_LO + TAG_FID_LO;

    // S0: input register
    logic              s0_vld;
    logic [WORD_W-1:0] s0_data;
    // S1: waits for the registered lookup read
    logic              s1_vld;
    logic [WORD_W-1:0] s1_data;

    logic [IDX_W-1:0]  lookup_idx;
    logic [ENT_W-1:0]  entry;

    lnp_state_e state, state_nxt;

    logic              wr_nxt;
    logic [WORD_W-1:0] data_nxt;
    logic              outpkt_nxt;
    logic              miss_nxt;
    logic              lost_nxt;
    logic              ovf_nxt;

    logic [1:0]          s1_type;
    logic                s1_head;
    logic                s1_body_or_tail;
    logic                s1_tail;
    logic [FLOWID_W-1:0] tag_fid;
    logic                hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_vld            <= 1'b0;
            s0_data           <= '0;
            s1_vld            <= 1'b0;
            s1_data           <= '0;
            o_lnp_inpkt_pulse <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every pipeline stage sample the old value of the previous one.
            s0_vld            <= i_lnp_pkt_data_wr;
            s0_data           <= iv_lnp_pkt_data;
            s1_vld            <= s0_vld;
            s1_data           <= s0_data;
            o_lnp_inpkt_pulse <= i_lnp_pkt_data_wr && (word_type(iv_lnp_pkt_data) == WT_HEAD);
        end
    end

    // The lookup address is taken from every S0 word; only head results are ever used.
    assign lookup_idx = s0_data[FID_BIT +: IDX_W];

    lnp_restore_table #(
        .IDX_W  (IDX_W),
        .DATA_W (ENT_W)
    ) u_table (
        .clk     (clk),
        .rst     (rst),
        .a_addr  (iv_lnp_rmt_ram_addr),
        .a_wr    (i_lnp_rmt_ram_wr),
        .a_wdata (iv_lnp_rmt_ram_wdata),
        .a_rd    (i_lnp_rmt_ram_rd),
        .a_rdata (ov_lnp_rmt_ram_rdata),
        .b_addr  (lookup_idx),
        .b_rdata (entry)
    );

    assign s1_type         = word_type(s1_data);
    assign s1_head         = s1_vld && (s1_type == WT_HEAD);
    assign s1_tail         = s1_vld && (s1_type == WT_TAIL);
    assign s1_body_or_tail = s1_vld && ((s1_type == WT_BODY) || (s1_type == WT_TAIL));
    assign tag_fid         = s1_data[FID_BIT +: FLOWID_W];
    assign hit             = entry[ENT_VALID] && (entry[ENT_FID_LO +: FLOWID_W] == tag_fid);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A head always starts a new packet whatever the state, which also silently
    // closes a forwarded packet whose tail was lost.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt  = state;
        wr_nxt     = 1'b0;
        data_nxt   = s1_data;
        outpkt_nxt = 1'b0;
        miss_nxt   = 1'b0;
        lost_nxt   = 1'b0;

        if (s1_head) begin
            miss_nxt = !hit;
            if (hit && !i_lnp_fifo_full) begin
                state_nxt                  = ST_FWD;
                wr_nxt                     = 1'b1;
                data_nxt[DMAC_HI:DMAC_LO]  = entry[ENT_DMAC_LO +: MAC_W];
`ifdef LNP_MISS_PASS_EN
            end else if (!i_lnp_fifo_full) begin
                state_nxt                  = ST_FWD;
                wr_nxt                     = 1'b1;
                data_nxt[DMAC_HI:DMAC_LO]  = BCAST_MAC;
`endif
            end else begin
                state_nxt = ST_DROP;
            end
        end else if (s1_body_or_tail) begin
            case (state)
                ST_IDLE: begin
                    lost_nxt = 1'b1;
                end
                ST_FWD: begin
                    wr_nxt = 1'b1;
                    if (s1_tail) begin
                        outpkt_nxt = 1'b1;
                        state_nxt  = ST_IDLE;
                    end
                end
                ST_DROP: begin
                    if (s1_tail) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Full is only honoured at the head; mid-packet it is reported, not obeyed.
    assign ovf_nxt = wr_nxt && i_lnp_fifo_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_lnp_pkt_data_wr     <= 1'b0;
            ov_lnp_pkt_data       <= '0;
            o_lnp_outpkt_pulse    <= 1'b0;
            o_lnp_miss_pulse      <= 1'b0;
            o_lnp_lost_head_pulse <= 1'b0;
            o_lnp_fifo_overflow   <= 1'b0;
        end else begin
            o_lnp_pkt_data_wr     <= wr_nxt;
            o_lnp_outpkt_pulse    <= outpkt_nxt;
            o_lnp_miss_pulse      <= miss_nxt;
            o_lnp_lost_head_pulse <= lost_nxt;
            o_lnp_fifo_overflow   <= ovf_nxt;
            if (wr_nxt) begin
                ov_lnp_pkt_data <= data_nxt;
            end
        end
    end

endmodule

// File: tb/tb_last_node_process.sv
// Self-checking bench for last_node_process: a packet-level reference model compared
// every cycle, plus hand-computed per-scenario counts and head-word values.
module tb_last_node_process;
    import lnp_pkg::*;

    localparam int IDX_W    = 5;
    localparam int FLOWID_W = 14;
    localparam int MAXC     = 2000;
`ifdef LNP_MISS_PASS_EN
    localparam bit MISS_PASS = 1'b1;
`else
    localparam bit MISS_PASS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic [133:0] pkt_data;
    logic         pkt_wr;
    logic [4:0]   ram_addr;
    logic         ram_wr;
    logic [62:0]  ram_wdata;
    logic         ram_rd;
    logic [62:0]  ram_rdata;
    logic [133:0] out_data;
    logic         out_wr;
    logic         fifo_full;
    logic         inpkt_p, outpkt_p, miss_p, lost_p, ovf_p;

    always #5 clk = ~clk;

    last_node_process #(.IDX_W(IDX_W), .FLOWID_W(FLOWID_W)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .iv_lnp_pkt_data       (pkt_data),
        .i_lnp_pkt_data_wr     (pkt_wr),
        .iv_lnp_rmt_ram_addr   (ram_addr),
        .i_lnp_rmt_ram_wr      (ram_wr),
        .iv_lnp_rmt_ram_wdata  (ram_wdata),
        .i_lnp_rmt_ram_rd      (ram_rd),
        .ov_lnp_rmt_ram_rdata  (ram_rdata),
        .ov_lnp_pkt_data       (out_data),
        .o_lnp_pkt_data_wr     (out_wr),
        .i_lnp_fifo_full       (fifo_full),
        .o_lnp_inpkt_pulse     (inpkt_p),
        .o_lnp_outpkt_pulse    (outpkt_p),
        .o_lnp_miss_pulse      (miss_p),
        .o_lnp_lost_head_pulse (lost_p),
        .o_lnp_fifo_overflow   (ovf_p)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [133:0] act, input logic [133:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         exp_wr    [MAXC];
    logic [133:0] exp_data  [MAXC];
    logic [4:0]   exp_pulse [MAXC];   // {inpkt, outpkt, miss, lost_head, overflow}
    logic [62:0]  exp_rdata [MAXC];
    logic         w_vld     [MAXC];
    logic [133:0] w_data    [MAXC];
    logic         lk_hit    [MAXC];
    logic [47:0]  lk_dmac   [MAXC];
    logic [62:0]  m_tbl     [32];
    logic [62:0]  m_rdata;
    bit           pkt_open;      // current packet is being forwarded
    bit           pkt_dropping;  // current packet is being discarded

    int cnt_wr = 0, cnt_out = 0, cnt_miss = 0, cnt_lost = 0, cnt_ovf = 0;
    logic [133:0] last_head;

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            exp_wr[i] = 1'b0; exp_data[i] = '0; exp_pulse[i] = '0; exp_rdata[i] = '0;
            w_vld[i] = 1'b0; w_data[i] = '0; lk_hit[i] = 1'b0; lk_dmac[i] = '0;
        end
        for (int i = 0; i < 32; i++) m_tbl[i] = '0;
        m_rdata = '0;
        last_head = '0;
        pkt_open = 1'b0;
        pkt_dropping = 1'b0;
    end

    always @(negedge clk) begin : model_and_compare
        int n, k;
        logic [62:0]  ent;
        logic [13:0]  fid;
        logic [1:0]   t;
        logic [133:0] w;
        logic         emit;
        n = cyc;
        if (n + 2 < MAXC) begin
            // Track DUT activity for the per-scenario hand checks
            if (out_wr === 1'b1) begin
                cnt_wr++;
                if (out_data[133:132] == WT_HEAD) last_head = out_data;
            end
            if (outpkt_p === 1'b1) cnt_out++;
            if (miss_p === 1'b1) cnt_miss++;
            if (lost_p === 1'b1) cnt_lost++;
            if (ovf_p === 1'b1) cnt_ovf++;

            if (rst) begin
                check("reset_ctrl", {out_wr, inpkt_p, outpkt_p, miss_p, lost_p, ovf_p}, 6'b0);
                check("reset_data", out_data, '0);
                check("reset_rdata", ram_rdata, '0);
                w_vld[n] = 1'b0;
                exp_rdata[n+1] = '0;
                m_rdata = '0;
                pkt_open = 1'b0;
                pkt_dropping = 1'b0;
            end else begin
                check("wr", out_wr, exp_wr[n]);
                if (exp_wr[n]) check("data", out_data, exp_data[n]);
                check("pulses", {inpkt_p, outpkt_p, miss_p, lost_p, ovf_p}, exp_pulse[n]);
                check("cpu_rdata", ram_rdata, exp_rdata[n]);

                // CPU port: read returns contents before a same-cycle write
                if (ram_rd) m_rdata = m_tbl[ram_addr];
                exp_rdata[n+1] = m_rdata;
                if (ram_wr) m_tbl[ram_addr] = ram_wdata;

                exp_pulse[n+1][4] = pkt_wr && (pkt_data[133:132] == WT_HEAD);

                // Lookup result for this cycle's word sees writes up to and including this cycle
                w_vld[n]  = pkt_wr;
                w_data[n] = pkt_data;
                fid = pkt_data[124:111];
                ent = m_tbl[fid[4:0]];
                lk_hit[n]  = ent[62] && (ent[61:48] == fid);
                lk_dmac[n] = ent[47:0];

                // Packet decision for the word that arrived two cycles ago, seeing current full
                k = n - 2;
                emit = 1'b0;
                w = '0;
                if (k >= 0 && w_vld[k]) begin
                    w = w_data[k];
                    t = w[133:132];
                    if (t == WT_HEAD) begin
                        exp_pulse[n+1][2] = !lk_hit[k];
                        if ((lk_hit[k] || MISS_PASS) && !fifo_full) begin
                            w[127:80] = lk_hit[k] ? lk_dmac[k] : 48'hFFFF_FFFF_FFFF;
                            emit = 1'b1;
                            pkt_open = 1'b1;
                            pkt_dropping = 1'b0;
                        end else begin
                            pkt_open = 1'b0;
                            pkt_dropping = 1'b1;
                        end
                    end else if (t == WT_BODY || t == WT_TAIL) begin
                        if (pkt_open) begin
                            emit = 1'b1;
                            if (t == WT_TAIL) begin
                                exp_pulse[n+1][3] = 1'b1;
                                pkt_open = 1'b0;
                            end
                        end else if (pkt_dropping) begin
                            if (t == WT_TAIL) pkt_dropping = 1'b0;
                        end else begin
                            exp_pulse[n+1][1] = 1'b1;
                        end
                    end
                end
                if (emit) begin
                    exp_wr[n+1]       = 1'b1;
                    exp_data[n+1]     = w;
                    exp_pulse[n+1][0] = fifo_full;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic vld, input logic [133:0] w, input logic full,
                         input logic cw, input logic cr, input logic [4:0] ca, input logic [62:0] cd);
        @(posedge clk);
        #1;
        pkt_wr = vld; pkt_data = w; fifo_full = full;
        ram_wr = cw; ram_rd = cr; ram_addr = ca; ram_wdata = cd;
    endtask

    task automatic word(input logic [133:0] w, input logic full);
        drive(1'b1, w, full, 1'b0, 1'b0, 5'd0, '0);
    endtask

    task automatic idle(input int n, input logic full);
        for (int i = 0; i < n; i++) drive(1'b0, '0, full, 1'b0, 1'b0, 5'd0, '0);
    endtask

    function automatic logic [133:0] head(input logic [13:0] fid, input int k);
        logic [47:0] tag;
        tag = {3'b101, fid, 31'h1234_5678};
        return {WT_HEAD, 4'h0, tag, 16'hC0DE, 64'h0102_0304_0506_0700 + 64'(k)};
    endfunction

    function automatic logic [133:0] body(input int k);
        return {WT_BODY, 4'h0, {4{32'hA5A5_0000 + 32'(k)}}};
    endfunction

    function automatic logic [133:0] tail(input int k);
        return {WT_TAIL, 4'h5, {4{32'h5A5A_0000 + 32'(k)}}};
    endfunction

    task automatic send4(input logic [13:0] fid, input int k);
        word(head(fid, k), 1'b0);
        word(body(k), 1'b0);
        word(body(k + 1), 1'b0);
        word(tail(k), 1'b0);
    endtask

    int b_wr, b_out, b_miss, b_lost, b_ovf;
    task automatic mark();
        b_wr = cnt_wr; b_out = cnt_out; b_miss = cnt_miss; b_lost = cnt_lost; b_ovf = cnt_ovf;
    endtask

    task automatic expect_counts(input string name, input int wr, input int outp,
                                 input int miss, input int lost, input int ovf);
        idle(6, 1'b0);
        check({name, "_writes"}, 134'(cnt_wr - b_wr), 134'(wr));
        check({name, "_outpkt"}, 134'(cnt_out - b_out), 134'(outp));
        check({name, "_miss"}, 134'(cnt_miss - b_miss), 134'(miss));
        check({name, "_lost"}, 134'(cnt_lost - b_lost), 134'(lost));
        check({name, "_ovf"}, 134'(cnt_ovf - b_ovf), 134'(ovf));
    endtask

    localparam logic [47:0] MAC3 = 48'h0011_2233_4455;
    localparam logic [47:0] MAC7 = 48'h7777_8888_9999;
    localparam logic [47:0] MAC5 = 48'h5555_6666_7777;

    initial begin
        rst = 1'b1;
        pkt_wr = 1'b0; pkt_data = '0; fifo_full = 1'b0;
        ram_wr = 1'b0; ram_rd = 1'b0; ram_addr = '0; ram_wdata = '0;
        idle(3, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Table initialisation: everything invalid except flows 3 and 7
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 5'(i),
                  (i == 3) ? {1'b1, 14'd3, MAC3} : (i == 7) ? {1'b1, 14'd7, MAC7} : 63'd0);
        end
        idle(2, 1'b0);

        // Hit: tag replaced by entry 3's DMAC
        mark();
        send4(14'd3, 1);
        expect_counts("hit", 4, 1, 0, 0, 0);
        check("hit_head_literal", last_head, {WT_HEAD, 4'h0, MAC3, 16'hC0DE, 64'h0102_0304_0506_0701});

        // Flow ID 35 indexes entry 3 but its flow ID differs
        mark();
        send4(14'd35, 2);
`ifdef LNP_MISS_PASS_EN
        expect_counts("miss", 4, 1, 1, 0, 0);
        check("miss_head_bcast", last_head[127:80], 134'(48'hFFFF_FFFF_FFFF));
`else
        expect_counts("miss", 0, 0, 1, 0, 0);
`endif

        // Body and tail with no head
        mark();
        word(body(3), 1'b0);
        word(tail(3), 1'b0);
        expect_counts("lost", 0, 0, 0, 2, 0);

        // Full while the head is decided: dropped
        mark();
        word(head(14'd3, 4), 1'b1);
        word(body(4), 1'b1);
        word(body(5), 1'b1);
        word(tail(4), 1'b1);
        idle(2, 1'b1);
        expect_counts("full_head", 0, 0, 0, 0, 0);

        // Full rises as word 2 is written: all written, overflow on words 2-4
        mark();
        word(head(14'd3, 5), 1'b0);
        word(body(5), 1'b0);
        word(body(6), 1'b0);
        word(tail(5), 1'b1);
        idle(2, 1'b1);
        expect_counts("full_mid", 4, 1, 0, 0, 3);

        // Tail lost: second head closes the first packet
        mark();
        word(head(14'd3, 6), 1'b0);
        word(body(6), 1'b0);
        word(head(14'd7, 7), 1'b0);
        word(body(7), 1'b0);
        word(body(8), 1'b0);
        word(tail(7), 1'b0);
        expect_counts("no_tail", 6, 1, 0, 0, 0);
        check("no_tail_head2", last_head, {WT_HEAD, 4'h0, MAC7, 16'hC0DE, 64'h0102_0304_0506_0707});

        // Entry 5 written while the flow-5 head sits in S0: lookup sees the old invalid entry
        mark();
        word(head(14'd5, 8), 1'b0);
        drive(1'b1, body(8), 1'b0, 1'b1, 1'b0, 5'd5, {1'b1, 14'd5, MAC5});
        word(body(9), 1'b0);
        word(tail(8), 1'b0);
`ifdef LNP_MISS_PASS_EN
        expect_counts("wr_collide", 4, 1, 1, 0, 0);
`else
        expect_counts("wr_collide", 0, 0, 1, 0, 0);
`endif
        mark();
        send4(14'd5, 9);
        expect_counts("after_wr", 4, 1, 0, 0, 0);
        check("after_wr_head", last_head, {WT_HEAD, 4'h0, MAC5, 16'hC0DE, 64'h0102_0304_0506_0709});

        // CPU readback of entry 5, one cycle after the strobe
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 5'd5, '0);
        idle(1, 1'b0);
        check("cpu_read5", ram_rdata, {1'b1, 14'd5, MAC5});

        // Back-to-back packets at full rate
        mark();
        send4(14'd3, 10);
        send4(14'd7, 11);
        expect_counts("b2b", 8, 2, 0, 0, 0);

        idle(3, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
